// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes the two encoder channels, decodes
// legal Gray-code steps into an up/down position count and flags illegal jumps.
//
// Parameters:
//   WIDTH        position counter width
//   SYNC_STAGES  synchronizer depth per channel (>= 2)
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   enc_a, enc_b        asynchronous encoder channels
//   enable              1 = accepted steps move count, 0 = steps discarded
//   load, d_in          preset count (highest priority after rst)
//   clr_err             clear sticky err (an illegal jump in the same cycle wins)
//   count               registered position, wraps modulo 2^WIDTH
//   step_up, step_dn    one-cycle pulses per accepted step
//   dir                 direction of last accepted step (1 = up)
//   err                 sticky illegal-transition flag
// Optional build macro QDEC_GLITCH_FILTER_EN: adds a 3-sample stability
// filter between the synchronizer and the decoder.

module quad_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] count,
    output logic             step_up,
    output logic             step_dn,
    output logic             dir,
    output logic             err
);

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int ARM_LEN = SYNC_STAGES + 3;
`else
    localparam int ARM_LEN = SYNC_STAGES + 1;
`endif
    localparam int HW = $clog2(ARM_LEN + 1);

    typedef enum logic {ARM = 1'b0, RUN = 1'b1} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [HW-1:0]        holdoff;
    logic [HW-1:0]        holdoff_nxt;
    logic                 run;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             raw;
    logic [1:0]             dec_in;
    logic [1:0]             prev;

    logic                 up_det;
    logic                 dn_det;
    logic                 bad_det;

    // Synchronizers and prev are intentionally not reset; ARM flushes them.
    always_ff @(posedge clk) begin
        sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
        sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
    end

    assign raw = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

`ifdef QDEC_GLITCH_FILTER_EN
    logic [1:0] hist1;
    logic [1:0] hist2;
    logic [1:0] filt;

    // A value is passed on once the current sample and the two before it
    // agree; otherwise the last accepted value is held.
    always_ff @(posedge clk) begin
        hist1 <= raw;
        hist2 <= hist1;
        filt  <= dec_in;
    end

    assign dec_in = (raw == hist1 && hist1 == hist2) ? raw : filt;
`else
    assign dec_in = raw;
`endif

    always_ff @(posedge clk) begin
        prev <= dec_in;
    end

    // Transition decode on {prev, current}; A leads B for up.
    always_comb begin
        up_det  = 1'b0;
        dn_det  = 1'b0;
        bad_det = 1'b0;
        case ({prev, dec_in})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: up_det  = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: dn_det  = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: bad_det = 1'b1;
            default: ;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARM;
            holdoff <= '0;
        end else begin
            state   <= state_nxt;
            holdoff <= holdoff_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt   = state;
        holdoff_nxt = holdoff;
        unique case (state)
            ARM: begin
                if (holdoff == HW'(ARM_LEN - 1))
                    state_nxt = RUN;
                else
                    holdoff_nxt = holdoff + 1'b1;
            end
            RUN: ;
            default: state_nxt = ARM;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            if (load) begin
                count <= d_in;
            end else if (run && enable && up_det) begin
                count   <= count + WIDTH'(1);
                step_up <= 1'b1;
                dir     <= 1'b1;
            end else if (run && enable && dn_det) begin
                count   <= count - WIDTH'(1);
                step_dn <= 1'b1;
                dir     <= 1'b0;
            end
            if (run && bad_det)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
        end
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, position counter width in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (minimum 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 enc_a  input  1  encoder channel A; asynchronous to clk.
REQ-006 enc_b  input  1  encoder channel B; asynchronous to clk.
REQ-007 enable  input  1  1 = decoded steps update count; 0 = hold.
REQ-008 load  input  1  1 = count takes d_in on the next edge.
REQ-009 d_in  input  WIDTH  preset value for load.
REQ-010 clr_err  input  1  1 = clear the sticky err flag.
REQ-011 count  output  WIDTH  registered position.
REQ-012 step_up  output  1  registered one-cycle pulse per accepted up step.
REQ-013 step_dn  output  1  registered one-cycle pulse per accepted down step.
REQ-014 dir  output  1  direction of the last accepted step: 1 = up, 0 = down.
REQ-015 err  output  1  sticky flag for an illegal (two-bit) transition.

Function
REQ-016 Each of enc_a and enc_b SHALL pass through its own SYNC_STAGES-flop synchronizer; the decoder uses only the synchronized pair {A,B}.
REQ-017 The decoder SHALL keep a prev {A,B} register, updated every cycle to the current synchronized pair.
REQ-018 Up steps SHALL be the transitions 00->10, 10->11, 11->01, 01->00 (A leads B).
REQ-019 Down steps SHALL be the reverse transitions 00->01, 01->11, 11->10, 10->00.
REQ-020 An unchanged {A,B} SHALL cause no action.
REQ-021 The transitions 00<->11 and 01<->10 SHALL be illegal: they set err, leave count unchanged and produce no pulse.
REQ-022 Control FSM states: ARM and RUN.
- ARM is entered on reset and lasts SYNC_STAGES+1 cycles, counted by a holdoff counter.
- In ARM, prev tracks the synchronized pair; no counting, no pulses, no err.
- ARM then goes to RUN; RUN exits only on rst.
REQ-023 Latency with SYNC_STAGES=2: an encoder edge set up before clock edge 1 SHALL appear on count, dir and the pulse on edge 3.
REQ-024 Per-cycle priority SHALL be load > (enable && legal step) > hold.
REQ-025 When load=1, count SHALL take d_in and step_up, step_dn and dir SHALL be unchanged or deasserted, even if a step occurs in the same cycle.
REQ-026 When enable=0, steps SHALL be discarded: prev still tracks, no pulses, no catch-up on re-enable.
REQ-027 err detection SHALL be independent of enable.
REQ-028 count arithmetic SHALL wrap modulo 2^WIDTH: max+1 -> 0 and 0-1 -> max.
REQ-029 clr_err=1 SHALL clear err, except when an illegal transition occurs in the same cycle, in which case the set wins and err stays 1.
REQ-030 step_up and step_dn SHALL never both be 1 in the same cycle.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL reset count=0, step_up=0, step_dn=0, dir=0, err=0, FSM=ARM and holdoff=0.
REQ-032 rst asserted mid-operation SHALL take effect on that edge, overriding load and any step.
REQ-033 Synchronizer flops and prev SHALL NOT be reset; ARM initializes prev.

Configuration
REQ-034 Macro QDEC_GLITCH_FILTER_EN, when defined, SHALL insert a stability filter between the synchronizer and the decoder.
- A new {A,B} value is accepted only after it is identical on 3 consecutive clock edges.
- Pulses shorter than 3 cycles are ignored.
- Latency becomes edge 5.
- ARM length becomes SYNC_STAGES+3 cycles.
REQ-035 Without QDEC_GLITCH_FILTER_EN, the synchronized pair SHALL feed the decoder directly, with no filter logic present.

Verification
REQ-036 Reset, then hold enc={1,1} for 10 cycles -> count=0, err=0, no pulses; no false step from the ARM exit.
REQ-037 Load d_in=7, then apply 4 up steps (00,10,11,01,00) spaced 4 cycles apart -> count=B, 4 step_up pulses, dir=1; then apply 3 down steps -> count=8, dir=0.
REQ-038 With enable=0, apply 2 up steps -> count holds 8 with no pulses; set enable=1 -> count stays 8.
REQ-039 Wrap: load F, then 1 up step -> count=0; 1 down step -> count=F.
REQ-040 Apply the illegal transition 00->11 -> err=1, count unchanged; clr_err -> err=0; illegal transition together with clr_err in the same cycle -> err=1.
REQ-041 Load C coincident with an up step -> count=C, no pulse; assert rst mid-count -> count=0 on the next edge; under QDEC_GLITCH_FILTER_EN, a 2-cycle A pulse -> no step.
